muldiv_ctrl: RTL
================

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 Parameter XLEN, default 32, datapath width.
REQ-002 Parameter MUL_LAT, default 3, fixed multiplier latency in cycles from start to valid fu_result_i.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_ni  input  1  reset, synchronous, active-low.
REQ-005 req_valid_i  input  1  EX stage holds a valid instruction.
REQ-006 opcode_i / funct3_i / funct7_i  input  7/3/7  instruction decode fields.
REQ-007 op_a_i / op_b_i  input  XLEN  forwarded rs1 / rs2 operands.
REQ-008 rd_i  input  5  destination register.
REQ-009 flush_i  input  1  kill in-flight operation (branch taken / trap).
REQ-010 fu_start_o  output  1  one-cycle start pulse to the multiply/divide unit.
REQ-011 fu_is_div_o / fu_op_o  output  1/3  unit operation select (funct3), held from start until completion.
REQ-012 fu_a_o / fu_b_o  output  XLEN  latched operands, held from start until completion.
REQ-013 fu_kill_o  output  1  one-cycle abort pulse to the unit.
REQ-014 fu_done_i / fu_result_i  input  1/XLEN  divider completion strobe; result bus.
REQ-015 stall_o  output  1  freeze IF/ID/EX; ex_valid equals !stall_o.
REQ-016 result_valid_o / result_o / rd_o  output  1/XLEN/5  completed result for WB.

Function
REQ-017 M-op decode: opcode 7'b0110011 and funct7 7'b0000001; funct3[2]=0 multiply, 1 divide/remainder.
REQ-018 States: IDLE, MUL, DIV, DONE; encoding is free.
REQ-019 IDLE, req_valid_i & M-op & !flush_i: accept; latch operands, funct3, rd_i; stall_o=1 combinationally in the accept cycle.
REQ-020 Accept, multiply: fu_start_o=1 in the accept cycle; load counter with MUL_LAT-1; go MUL.
REQ-021 Accept, divide with op_b_i != 0 and not overflow: fu_start_o=1 in the accept cycle; go DIV.
REQ-022 Divide by zero: no fu_start_o; result = all ones for DIV/DIVU, op_a_i for REM/REMU; go DONE.
REQ-023 Signed overflow (DIV/REM, op_a_i=0x80000000, op_b_i=0xFFFFFFFF): no fu_start_o; result 0x80000000 for DIV, 0 for REM; go DONE.
REQ-024 MUL: stall_o=1; counter decrements each cycle; at counter 0 capture fu_result_i and go DONE. Total accept-to-DONE = MUL_LAT cycles.
REQ-025 DIV: stall_o=1; wait for fu_done_i, with no timeout; on fu_done_i capture fu_result_i and go DONE.
REQ-026 DONE: stall_o=0; result_valid_o=1 for exactly one cycle with captured result_o and rd_o; always return to IDLE.
REQ-027 A new M-op presented during DONE is not accepted until the following IDLE cycle.
REQ-028 flush_i in MUL/DIV: fu_kill_o=1 same cycle, stall_o=0, return to IDLE; no result_valid_o for the killed op.
REQ-029 flush_i in DONE: result_valid_o forced to 0; return to IDLE.
REQ-030 flush_i in IDLE: no accept, no fu_start_o.
REQ-031 fu_done_i while in IDLE, MUL or DONE: ignored.
REQ-032 Non-M-op or !req_valid_i in IDLE: stall_o=0, no state change.
REQ-033 Simultaneous fu_done_i and flush_i in DIV: flush wins; result discarded.

Reset
REQ-034 When rst_ni=0 at a clock edge: state=IDLE, counter=0, latched operands/result/rd cleared to 0.
REQ-035 Outputs after reset: stall_o=0, fu_start_o=0, fu_kill_o=0, result_valid_o=0.
REQ-036 Reset mid-operation: abort with no fu_kill_o and no result; the unit is reset by the same rst_ni.

Verification
REQ-037 MUL 7 x 6, rd=5, MUL_LAT=3 -> fu_start_o at cycle 0, stall_o cycles 0-2, result_valid_o cycle 3 with result_o=42, rd_o=5.
REQ-038 DIVU 100 / 7 with fu_done_i at cycle 10 -> stall_o cycles 0-10, result_valid_o cycle 11 with result_o=14.
REQ-039 REM 0x80000000 % 0xFFFFFFFF -> no fu_start_o, result_valid_o next cycle with result_o=0; DIV 5 / 0 -> result_o=0xFFFFFFFF.
REQ-040 DIV in flight, flush_i asserted at cycle 4 -> fu_kill_o=1 and stall_o=0 at cycle 4; no result_valid_o afterwards.
REQ-041 ADD (opcode 0110011, funct7 0) with req_valid_i=1 -> stall_o=0; no fu_start_o.
REQ-042 rst_ni=0 during MUL -> next cycle IDLE with all outputs 0; subsequent MUL 3 x 3 yields result_o=9.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// Multiply/divide controller sitting beside the EX stage.
// Decodes RV32M instructions, launches the multi-cycle unit, stalls the
// pipeline while the unit is busy and hands the result to writeback.
// Divide-by-zero and signed overflow are resolved here without starting
// the unit. Assumes MUL_LAT >= 2.
module muldiv_ctrl #(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 3
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_valid_i,
  input  logic [6:0]      opcode_i,
  input  logic [2:0]      funct3_i,
  input  logic [6:0]      funct7_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic [4:0]      rd_i,
  input  logic            flush_i,
  output logic            fu_start_o,
  output logic            fu_is_div_o,
  output logic [2:0]      fu_op_o,
  output logic [XLEN-1:0] fu_a_o,
  output logic [XLEN-1:0] fu_b_o,
  output logic            fu_kill_o,
  input  logic            fu_done_i,
  input  logic [XLEN-1:0] fu_result_i,
  output logic            stall_o,
  output logic            result_valid_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o
);

  localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0]  ALL_ONES = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

  state_t          state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;
  logic [2:0]      f3_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] res_q;

  logic            is_mop;
  logic            accept;
  logic            is_div_req;
  logic            div_by_zero;
  logic            div_ovf;
  logic            bypass_fu;
  logic            busy;
  logic [XLEN-1:0] bypass_result;

  assign is_mop      = (opcode_i == 7'b0110011) && (funct7_i == 7'b0000001);
  assign accept      = (state_q == S_IDLE) && req_valid_i && is_mop && !flush_i;
  assign is_div_req  = funct3_i[2];
  assign div_by_zero = (op_b_i == '0);
  // Only DIV/REM (funct3[0]=0) are signed and can overflow.
  assign div_ovf     = !funct3_i[0] && (op_a_i == INT_MIN) && (op_b_i == ALL_ONES);
  assign bypass_fu   = is_div_req && (div_by_zero || div_ovf);
  assign busy        = (state_q == S_MUL) || (state_q == S_DIV);

  // Architectural result for the corner cases the unit never sees.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    bypass_result = '0;
    if (div_by_zero) begin
      bypass_result = funct3_i[1] ? op_a_i : ALL_ONES;
    end else begin
      bypass_result = funct3_i[1] ? '0 : INT_MIN;
    end
  end

  // Start, stall and kill must act in the same cycle as the decision, so
  // they are decoded from the current state and inputs.
  assign fu_start_o     = accept && !bypass_fu;
  assign fu_kill_o      = busy && flush_i;
  assign stall_o        = accept || (busy && !flush_i);
  assign result_valid_o = (state_q == S_DONE) && !flush_i;

  // Operands and op select come straight from EX in the start cycle and
  // from the latched copies while the unit works.
  assign fu_a_o      = accept ? op_a_i : a_q;
  assign fu_b_o      = accept ? op_b_i : b_q;
  assign fu_op_o     = accept ? funct3_i : f3_q;
  assign fu_is_div_o = accept ? funct3_i[2] : f3_q[2];
  assign result_o    = res_q;
  assign rd_o        = rd_q;

  // Control FSM: accept, wait on the unit, present the result for one cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      // NOTE: sequential state uses non-blocking assignments only.
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      f3_q    <= '0;
      rd_q    <= '0;
      res_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            a_q  <= op_a_i;
            b_q  <= op_b_i;
            f3_q <= funct3_i;
            rd_q <= rd_i;
            if (!is_div_req) begin
              cnt_q   <= CNT_LOAD;
              state_q <= S_MUL;
            end else if (bypass_fu) begin
              res_q   <= bypass_result;
              state_q <= S_DONE;
            end else begin
              state_q <= S_DIV;
            end
          end
        end
        S_MUL: begin
          if (flush_i) begin
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
            // The counter reaches 0 on this edge: the product is valid now.
            if (cnt_q <= CNT_ONE) begin
              res_q   <= fu_result_i;
              state_q <= S_DONE;
            end
          end
        end
        S_DIV: begin
          if (flush_i) begin
            state_q <= S_IDLE;
          end else if (fu_done_i) begin
            res_q   <= fu_result_i;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
